// File: rtl/dn_rom_loader_pkg.sv
// Shared definitions for the ROM download loader: bus widths, default
// region sizes, region select indices and the loader state encoding.
package dn_rom_loader_pkg;

    localparam int unsigned ADDR_W    = 25;
    localparam int unsigned DN_ADDR_W = 17;

    localparam int unsigned DEF_CPU_SIZE  = 24576;
    localparam int unsigned DEF_GFX_SIZE  = 16384;
    localparam int unsigned DEF_SPCH_SIZE = 8192;
    localparam int unsigned DEF_PROM_SIZE = 64;
    localparam int unsigned DEF_RST_HOLD  = 16;

    // Bit positions inside the one-hot region select
    localparam int REG_CPU  = 0;
    localparam int REG_GFX  = 1;
    localparam int REG_SPCH = 2;
    localparam int REG_PROM = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        HOLD,
        RUN,
        ERR
    } state_e;

    // Length of a complete download image
    function automatic int unsigned total_size(input int unsigned cpu,
                                               input int unsigned gfx,
                                               input int unsigned spch,
                                               input int unsigned prom);
        return cpu + gfx + spch + prom;
    endfunction

endpackage

// File: rtl/dn_region_decode.sv
// Splits the linear download address into a one-hot region select and a
// region-relative offset. Regions are packed back to back from address 0
// in the order CPU, GFX, speech, PROM; anything beyond is out of range.
module dn_region_decode
    import dn_rom_loader_pkg::*;
#(
    parameter int unsigned CPU_SIZE  = DEF_CPU_SIZE,
    parameter int unsigned GFX_SIZE  = DEF_GFX_SIZE,
    parameter int unsigned SPCH_SIZE = DEF_SPCH_SIZE,
    parameter int unsigned PROM_SIZE = DEF_PROM_SIZE
) (
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [3:0]           sel_o,
    output logic [DN_ADDR_W-1:0] offset_o,
    output logic                 oor_o
);

    localparam logic [ADDR_W-1:0] GFX_BASE  = ADDR_W'(CPU_SIZE);
    localparam logic [ADDR_W-1:0] SPCH_BASE = ADDR_W'(CPU_SIZE + GFX_SIZE);
    localparam logic [ADDR_W-1:0] PROM_BASE = ADDR_W'(CPU_SIZE + GFX_SIZE + SPCH_SIZE);
    localparam logic [ADDR_W-1:0] END_ADDR  =
        ADDR_W'(total_size(CPU_SIZE, GFX_SIZE, SPCH_SIZE, PROM_SIZE));

    // Priority compare against ascending region bases picks the region
    always_comb begin
        sel_o    = '0;
        offset_o = '0;
        oor_o    = 1'b0;
        if (addr_i < GFX_BASE) begin
            sel_o[REG_CPU] = 1'b1;
            offset_o       = DN_ADDR_W'(addr_i);
        end else if (addr_i < SPCH_BASE) begin
            sel_o[REG_GFX] = 1'b1;
            offset_o       = DN_ADDR_W'(addr_i - GFX_BASE);
        end else if (addr_i < PROM_BASE) begin
            sel_o[REG_SPCH] = 1'b1;
            offset_o        = DN_ADDR_W'(addr_i - SPCH_BASE);
        end else if (addr_i < END_ADDR) begin
            sel_o[REG_PROM] = 1'b1;
            offset_o        = DN_ADDR_W'(addr_i - PROM_BASE);
        end else begin
            oor_o = 1'b1;
        end
    end

endmodule

// File: rtl/dn_rom_loader.sv
// Registers the HPS ioctl byte stream onto the core ROM write port, keeps a
// byte count and checksum of the download, and owns the core reset: the core
// is only released RST_HOLD cycles after a download of exactly the expected
// length with no out-of-range writes.
module dn_rom_loader
    import dn_rom_loader_pkg::*;
#(
    parameter int unsigned CPU_SIZE  = DEF_CPU_SIZE,
    parameter int unsigned GFX_SIZE  = DEF_GFX_SIZE,
    parameter int unsigned SPCH_SIZE = DEF_SPCH_SIZE,
    parameter int unsigned PROM_SIZE = DEF_PROM_SIZE,
    parameter int unsigned RST_HOLD  = DEF_RST_HOLD
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [ADDR_W-1:0]    ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic [DN_ADDR_W-1:0] dn_addr,
    output logic [7:0]           dn_data,
    output logic                 dn_wr,
    output logic [3:0]           dn_sel,
    output logic [16:0]          byte_count,
    output logic [7:0]           checksum,
    output logic                 load_error,
    output logic                 core_reset
);

    localparam logic [16:0] TOTAL =
        17'(total_size(CPU_SIZE, GFX_SIZE, SPCH_SIZE, PROM_SIZE));

    state_e                 state_q, state_d;
    logic [15:0]            hold_q, hold_d;
    logic                   dl_q;
    logic                   ovf_q;
    logic [DN_ADDR_W-1:0]   dn_addr_q;
    logic [7:0]             dn_data_q;
    logic                   dn_wr_q;
    logic [3:0]             dn_sel_q;
    logic [16:0]            byte_count_q;
    logic [7:0]             checksum_q;
    logic                   load_error_q;
    logic                   core_reset_q;

    logic [3:0]             dec_sel;
    logic [DN_ADDR_W-1:0]   dec_offset;
    logic                   dec_oor;
    logic                   dl_rise, dl_fall;
    logic                   accept, overflow_wr;
    logic                   start_load, set_err;

    dn_region_decode #(
        .CPU_SIZE  (CPU_SIZE),
        .GFX_SIZE  (GFX_SIZE),
        .SPCH_SIZE (SPCH_SIZE),
        .PROM_SIZE (PROM_SIZE)
    ) u_decode (
        .addr_i   (ioctl_addr),
        .sel_o    (dec_sel),
        .offset_o (dec_offset),
        .oor_o    (dec_oor)
    );

    assign dl_rise     = ioctl_download & ~dl_q;
    assign dl_fall     = ~ioctl_download & dl_q;
    assign accept      = (state_q == LOAD) && ioctl_wr && !dec_oor;
    assign overflow_wr = (state_q == LOAD) && ioctl_wr && dec_oor;

    // Next-state logic; start_load marks every entry into LOAD so the
    // per-download statistics are cleared in exactly one place
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        start_load = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ioctl_download) begin
                    state_d    = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                if (dl_fall) state_d = CHECK;
            end
            CHECK: begin
                if (byte_count_q == TOTAL && !ovf_q) begin
                    state_d = HOLD;
                    hold_d  = 16'(RST_HOLD);
                end else begin
                    state_d = ERR;
                    set_err = 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == '0) state_d = RUN;
                else              hold_d  = hold_q - 16'd1;
            end
            RUN, ERR: begin
                if (dl_rise) begin
                    state_d    = LOAD;
                    start_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, download edge detector and core reset; the core runs
    // only in RUN, so reset is re-asserted on the same edge that leaves it
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            dl_q         <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            dl_q         <= ioctl_download;
            core_reset_q <= (state_d != RUN);
        end
    end

    // Write port: one-cycle strobe, address/select/data hold between writes
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dn_wr_q   <= 1'b0;
            dn_addr_q <= '0;
            dn_data_q <= '0;
            dn_sel_q  <= '0;
        end else begin
            dn_wr_q <= accept;
            if (accept) begin
                dn_addr_q <= dec_offset;
                dn_data_q <= ioctl_dout;
                dn_sel_q  <= dec_sel;
            end
        end
    end

    // Download statistics: saturating byte count, mod-256 checksum,
    // out-of-range flag and the sticky length error
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byte_count_q <= '0;
            checksum_q   <= '0;
            ovf_q        <= 1'b0;
            load_error_q <= 1'b0;
        end else if (start_load) begin
            byte_count_q <= '0;
            checksum_q   <= '0;
            ovf_q        <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            if (accept) begin
                if (byte_count_q != '1) byte_count_q <= byte_count_q + 17'd1;
                checksum_q <= checksum_q + ioctl_dout;
            end
            if (overflow_wr) ovf_q        <= 1'b1;
            if (set_err)     load_error_q <= 1'b1;
        end
    end

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign dn_sel     = dn_sel_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;
    assign load_error = load_error_q;
    assign core_reset = core_reset_q;

endmodule

// File: tb/tb_dn_rom_loader.sv
// Testbench for dn_rom_loader. Stimulus pushes each expected ROM write into
// a queue; a monitor on the falling clock edge pops and compares every dn_wr
// pulse. Status outputs are checked directly at chosen points.
module tb_dn_rom_loader;
    import dn_rom_loader_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [3:0]  dn_sel;
    logic [16:0] byte_count;
    logic [7:0]  checksum;
    logic        load_error;
    logic        core_reset;

    typedef struct packed {
        logic [3:0]  sel;
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        expQ[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         expCount   = 0;
    logic [7:0] expSum     = 8'h00;

    dn_rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .dn_sel         (dn_sel),
        .byte_count     (byte_count),
        .checksum       (checksum),
        .load_error     (load_error),
        .core_reset     (core_reset)
    );

    // Free-running system clock
    always #5 clk_sys = ~clk_sys;

    // Reference region map: CPU 0..24575, GFX 24576..40959,
    // speech 40960..49151, PROM 49152..49215
    function automatic wr_t expectedWrite(input int addr, input logic [7:0] data);
        wr_t w;
        w.data = data;
        if (addr < 24576) begin
            w.sel = 4'b0001; w.addr = 17'(addr);
        end else if (addr < 40960) begin
            w.sel = 4'b0010; w.addr = 17'(addr - 24576);
        end else if (addr < 49152) begin
            w.sel = 4'b0100; w.addr = 17'(addr - 40960);
        end else begin
            w.sel = 4'b1000; w.addr = 17'(addr - 49152);
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one ioctl byte for one cycle, called and returning at a negedge
    task automatic applyStimulus(input int addr, input logic [7:0] data, input bit expAcc);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = data;
        if (expAcc) begin
            expQ.push_back(expectedWrite(addr, data));
            expCount++;
            expSum = expSum + data;
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic startDownload();
        ioctl_download = 1'b1;
        expCount = 0;
        expSum   = 8'h00;
        @(negedge clk_sys);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation
    always @(negedge clk_sys) begin
        if (dn_wr === 1'b1) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_dn_wr: got sel=%b addr=%0d data=0x%0h, expected no write",
                         dn_sel, dn_addr, dn_data);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                if ({dn_sel, dn_addr, dn_data} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL dn_write: got sel=%b addr=%0d data=0x%0h, expected sel=%b addr=%0d data=0x%0h",
                             dn_sel, dn_addr, dn_data, e.sel, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) @(negedge clk_sys);

        $display("[TB] reset values");
        checkOutput("rst_dn_wr",      32'(dn_wr), 32'd0);
        checkOutput("rst_dn_sel",     32'(dn_sel), 32'd0);
        checkOutput("rst_dn_addr",    32'(dn_addr), 32'd0);
        checkOutput("rst_dn_data",    32'(dn_data), 32'd0);
        checkOutput("rst_byte_count", 32'(byte_count), 32'd0);
        checkOutput("rst_checksum",   32'(checksum), 32'd0);
        checkOutput("rst_load_error", 32'(load_error), 32'd0);
        checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk_sys);

        $display("[TB] boundary writes and overflow");
        startDownload();
        applyStimulus(24576, 8'h5A, 1'b1);
        checkOutput("gfx0_dn_wr",   32'(dn_wr), 32'd1);
        checkOutput("gfx0_dn_sel",  32'(dn_sel), 32'b0010);
        checkOutput("gfx0_dn_addr", 32'(dn_addr), 32'd0);
        checkOutput("gfx0_dn_data", 32'(dn_data), 32'h5A);
        applyStimulus(49215, 8'h77, 1'b1);
        checkOutput("prom_last_dn_sel",  32'(dn_sel), 32'b1000);
        checkOutput("prom_last_dn_addr", 32'(dn_addr), 32'd63);
        applyStimulus(49216, 8'h33, 1'b0);
        checkOutput("oor_dn_wr",      32'(dn_wr), 32'd0);
        checkOutput("oor_sel_hold",   32'(dn_sel), 32'b1000);
        checkOutput("oor_addr_hold",  32'(dn_addr), 32'd63);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        checkOutput("oor_load_error", 32'(load_error), 32'd1);
        checkOutput("oor_core_reset", 32'(core_reset), 32'd1);
        checkOutput("oor_byte_count", 32'(byte_count), 32'(expCount));
        checkOutput("oor_checksum",   32'(checksum), 32'(expSum));
        applyStimulus(10, 8'h99, 1'b0);
        checkOutput("err_wr_ignored", 32'(dn_wr), 32'd0);

        $display("[TB] short download");
        startDownload();
        checkOutput("short_err_cleared", 32'(load_error), 32'd0);
        for (int i = 0; i < 100; i++) applyStimulus(i, 8'(i), 1'b1);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        checkOutput("short_load_error", 32'(load_error), 32'd1);
        checkOutput("short_byte_count", 32'(byte_count), 32'(expCount));
        checkOutput("short_checksum",   32'(checksum), 32'(expSum));
        repeat (20) @(negedge clk_sys);
        checkOutput("short_core_reset", 32'(core_reset), 32'd1);

        $display("[TB] full download");
        startDownload();
        checkOutput("full_start_err", 32'(load_error), 32'd0);
        checkOutput("full_start_cnt", 32'(byte_count), 32'd0);
        for (int i = 0; i < 49216; i++) begin
            if (i == 49215) ioctl_download = 1'b0;
            applyStimulus(i, 8'(i), 1'b1);
        end
        checkOutput("full_byte_count", 32'(byte_count), 32'd49216);
        // 192 full 0..255 sweeps sum to 0 mod 256; the tail 0..63 adds 2016 = 0x7E0
        checkOutput("full_checksum",       32'(checksum), 32'hE0);
        checkOutput("full_checksum_model", 32'(checksum), 32'(expSum));
        repeat (17) @(negedge clk_sys);
        checkOutput("hold_core_reset_high", 32'(core_reset), 32'd1);
        checkOutput("hold_load_error",      32'(load_error), 32'd0);
        @(negedge clk_sys);
        checkOutput("run_core_reset_low", 32'(core_reset), 32'd0);
        applyStimulus(3, 8'h44, 1'b0);
        checkOutput("run_wr_ignored", 32'(dn_wr), 32'd0);

        $display("[TB] reload from RUN");
        startDownload();
        checkOutput("reload_core_reset", 32'(core_reset), 32'd1);
        checkOutput("reload_byte_count", 32'(byte_count), 32'd0);
        checkOutput("reload_checksum",   32'(checksum), 32'd0);
        applyStimulus(1, 8'hAB, 1'b1);
        applyStimulus(24577, 8'hCD, 1'b1);
        checkOutput("reload_count2", 32'(byte_count), 32'd2);

        $display("[TB] reset during load");
        reset      = 1'b1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd2;
        ioctl_dout = 8'h22;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        checkOutput("midrst_dn_wr",      32'(dn_wr), 32'd0);
        checkOutput("midrst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("midrst_checksum",   32'(checksum), 32'd0);
        checkOutput("midrst_byte_count", 32'(byte_count), 32'd0);
        checkOutput("midrst_state",      32'(dut.state_q), 32'(IDLE));
        reset          = 1'b0;
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
